// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: forwarding selects, load-use and long-op interlocks.
// Optional performance counters are compiled in with HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 5,
    parameter int LAT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_long,
    input  logic [LAT_W-1:0]     D_lat,
    input  logic [ADDR_SIZE-1:0] EX_rd,
    input  logic [ADDR_SIZE-1:0] MEM_rd,
    input  logic [ADDR_SIZE-1:0] WB_rd,
    input  logic                 EX_we,
    input  logic                 MEM_we,
    input  logic                 WB_we,
    input  logic                 EX_ld,
    input  logic                 flush,
    output logic                 stall_D,
    output logic [1:0]           ra_sel,
    output logic [1:0]           rb_sel,
    output logic                 long_busy
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_fwd_cnt
`endif
);

    // XLEN has no datapath in this block; it is only carried for parameter compatibility.
    if (XLEN < 1) begin : g_xlen_unused
    end

    logic [LAT_W-1:0]     l_cnt_q, l_cnt_d;
    logic [ADDR_SIZE-1:0] l_rd_q, l_rd_d;

    logic                           active;
    logic                           issue;
    logic                           load_use;
    logic                           long_raw;
    logic                           long_waw;
    logic                           structural;
    logic [1:0][ADDR_SIZE-1:0]      src;
    logic [1:0][1:0]                sel_w;
    logic [1:0]                     ld_hit;
    logic [1:0]                     l_hit;

    assign active    = D_valid && !flush;
    assign long_busy = (l_cnt_q != '0);
    assign src       = {D_rb, D_ra};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic nz;
            logic ex_hit;
            logic mem_hit;
            logic wb_hit;

            // Register 0 is hard-wired, so it never produces a hazard or a forward.
            assign nz      = (src[gi] != '0);
            assign ex_hit  = nz && EX_we  && (EX_rd  == src[gi]);
            assign mem_hit = nz && MEM_we && (MEM_rd == src[gi]);
            assign wb_hit  = nz && WB_we  && (WB_rd  == src[gi]);

            assign sel_w[gi] = !active              ? 2'b00 :
                               (ex_hit && !EX_ld)   ? 2'b01 :
                               mem_hit              ? 2'b10 :
                               wb_hit               ? 2'b11 : 2'b00;

            assign ld_hit[gi] = ex_hit && EX_ld;
            assign l_hit[gi]  = nz && (l_rd_q == src[gi]);
        end
    endgenerate

    assign ra_sel     = sel_w[0];
    assign rb_sel     = sel_w[1];
    assign load_use   = |ld_hit;
    assign long_raw   = long_busy && (|l_hit);
    assign long_waw   = long_busy && D_we && (D_rd != '0) && (D_rd == l_rd_q);
    // The long unit only accepts a new op once the counter has fully drained.
    assign structural = D_long && long_busy;
    assign stall_D    = active && (load_use || long_raw || long_waw || structural);
    assign issue      = active && D_long && !stall_D;

    always_comb begin
        l_cnt_d = l_cnt_q;
        l_rd_d  = l_rd_q;
        if (issue) begin
            l_cnt_d = (D_lat == '0) ? LAT_W'(1) : D_lat;
            l_rd_d  = D_rd;
        end else if (l_cnt_q != '0) begin
            l_cnt_d = l_cnt_q - LAT_W'(1);
            if (l_cnt_q == LAT_W'(1)) begin
                l_rd_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_cnt_q <= '0;
            l_rd_q  <= '0;
        end else begin
            l_cnt_q <= l_cnt_d;
            l_rd_q  <= l_rd_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_fwd_q, perf_fwd_d;
    logic        fwd_any;

    assign fwd_any = (ra_sel != 2'b00) || (rb_sel != 2'b00);

    // Both counters saturate rather than wrap.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_fwd_d   = perf_fwd_q;
        if (stall_D && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (!stall_D && fwd_any && (perf_fwd_q != 32'hFFFF_FFFF)) begin
            perf_fwd_d = perf_fwd_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_fwd_q   <= perf_fwd_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the decode interlocks.
module tb_hazard_scoreboard;
    localparam int AW = 5;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          D_valid, D_we, D_long, EX_we, MEM_we, WB_we, EX_ld, flush;
    logic [AW-1:0] D_ra, D_rb, D_rd, EX_rd, MEM_rd, WB_rd;
    logic [LW-1:0] D_lat;
    logic          stall_D, long_busy;
    logic [1:0]    ra_sel, rb_sel;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0]   perf_stall_cnt, perf_fwd_cnt;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(.XLEN(32), .ADDR_SIZE(AW), .LAT_W(LW)) dut (
        .clk(clk), .rst(rst), .D_valid(D_valid), .D_ra(D_ra), .D_rb(D_rb), .D_rd(D_rd),
        .D_we(D_we), .D_long(D_long), .D_lat(D_lat), .EX_rd(EX_rd), .MEM_rd(MEM_rd),
        .WB_rd(WB_rd), .EX_we(EX_we), .MEM_we(MEM_we), .WB_we(WB_we), .EX_ld(EX_ld),
        .flush(flush), .stall_D(stall_D), .ra_sel(ra_sel), .rb_sel(rb_sel),
        .long_busy(long_busy)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    typedef struct {
        bit r, v, we, lg, exwe, exld, memwe, wbwe, fl;
        int ra, rb, rd, lat, exrd, memrd, wbrd;
    } stim_t;

    typedef struct {
        int          id;
        logic        stall;
        logic [1:0]  ra;
        logic [1:0]  rb;
        logic        busy;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   txn_id      = 0;

    // Model state: cycles the long unit is still occupied, its destination, perf totals.
    int      m_rem = 0;
    int      m_dst = 0;
    longint  m_ps  = 0;
    longint  m_pf  = 0;

    function automatic bit same_reg(int a, int b);
        return (a != 0) && (a == b);
    endfunction

    // Operand source by walking the older stages youngest-first.
    function automatic logic [1:0] source_of(stim_t s, int r);
        if (s.exwe && !s.exld && same_reg(s.exrd, r)) return 2'b01;
        if (s.memwe && same_reg(s.memrd, r))          return 2'b10;
        if (s.wbwe && same_reg(s.wbrd, r))            return 2'b11;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   act, busy, stall;
        @(posedge clk);
        #1;
        rst = s.r;  D_valid = s.v;  D_we = s.we;  D_long = s.lg;  flush = s.fl;
        D_ra = AW'(s.ra);  D_rb = AW'(s.rb);  D_rd = AW'(s.rd);  D_lat = LW'(s.lat);
        EX_rd = AW'(s.exrd);  EX_we = s.exwe;  EX_ld = s.exld;
        MEM_rd = AW'(s.memrd);  MEM_we = s.memwe;  WB_rd = AW'(s.wbrd);  WB_we = s.wbwe;

        act   = s.v && !s.fl;
        busy  = (m_rem > 0);
        stall = act && ((s.exld && s.exwe && (same_reg(s.exrd, s.ra) || same_reg(s.exrd, s.rb)))
                     || (busy && (same_reg(m_dst, s.ra) || same_reg(m_dst, s.rb)))
                     || (busy && s.we && same_reg(m_dst, s.rd))
                     || (busy && s.lg));
        e.id    = txn_id++;
        e.busy  = busy;
        e.stall = stall;
        e.ra    = act ? source_of(s, s.ra) : 2'b00;
        e.rb    = act ? source_of(s, s.rb) : 2'b00;
        e.ps    = 32'(m_ps);
        e.pf    = 32'(m_pf);
        q.push_back(e);

        if (s.r) begin
            m_rem = 0;  m_dst = 0;  m_ps = 0;  m_pf = 0;
        end else begin
            if (stall) m_ps = (m_ps < 64'hFFFF_FFFF) ? m_ps + 1 : m_ps;
            else if (e.ra != 0 || e.rb != 0) m_pf = (m_pf < 64'hFFFF_FFFF) ? m_pf + 1 : m_pf;
            if (act && s.lg && !stall) begin
                m_rem = (s.lat == 0) ? 1 : s.lat;
                m_dst = s.rd;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
        end
    endtask

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL txn %0d %s: got %0h expected %0h", id, name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            chk(e.id, "stall_D", 32'(stall_D), 32'(e.stall));
            chk(e.id, "ra_sel", 32'(ra_sel), 32'(e.ra));
            chk(e.id, "rb_sel", 32'(rb_sel), 32'(e.rb));
            chk(e.id, "long_busy", 32'(long_busy), 32'(e.busy));
`ifdef HAZARD_SCOREBOARD_PERF_EN
            chk(e.id, "perf_stall_cnt", perf_stall_cnt, e.ps);
            chk(e.id, "perf_fwd_cnt", perf_fwd_cnt, e.pf);
`endif
            $display("txn %0d stall=%0b ra_sel=%0d rb_sel=%0d busy=%0b", e.id, stall_D, ra_sel, rb_sel, long_busy);
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;  D_valid = 0;  D_we = 0;  D_long = 0;  flush = 0;
        D_ra = 0;  D_rb = 0;  D_rd = 0;  D_lat = 0;
        EX_rd = 0;  EX_we = 0;  EX_ld = 0;  MEM_rd = 0;  MEM_we = 0;  WB_rd = 0;  WB_we = 0;

        s = idle();  s.r = 1;  step(s);
        step(idle());

        // Forward priority EX over MEM, then MEM once EX stops writing.
        s = idle();  s.v = 1;  s.ra = 3;  s.exwe = 1;  s.exrd = 3;  s.memwe = 1;  s.memrd = 3;
        step(s);
        s.exwe = 0;  step(s);

        // Load-use stall, then register 0 never matches.
        s = idle();  s.v = 1;  s.rb = 5;  s.exld = 1;  s.exwe = 1;  s.exrd = 5;
        step(s);
        s.rb = 0;  s.exrd = 0;  step(s);

        // Long op latency 3 to r7, dependent reader waits out the busy window.
        s = idle();  s.v = 1;  s.lg = 1;  s.lat = 3;  s.rd = 7;  s.we = 1;
        step(s);
        s = idle();  s.v = 1;  s.ra = 7;
        repeat (4) step(s);

        // Structural stall with L_cnt=1, then issue the next cycle.
        s = idle();  s.v = 1;  s.lg = 1;  s.lat = 2;  s.rd = 4;  s.we = 1;
        step(s);
        step(idle());
        s.lat = 5;  s.rd = 9;
        step(s);
        step(s);
        repeat (6) step(idle());

        // Flush blocks issue; reset abandons a latency-5 op.
        s = idle();  s.v = 1;  s.lg = 1;  s.lat = 3;  s.rd = 6;  s.fl = 1;
        step(s);
        step(idle());
        s.fl = 0;  s.lat = 5;  step(s);
        s = idle();  s.r = 1;  step(s);
        step(idle());

        // Four load-use stalls then two forwarding cycles out of reset.
        s = idle();  s.r = 1;  step(s);
        s = idle();  s.v = 1;  s.ra = 2;  s.exld = 1;  s.exwe = 1;  s.exrd = 2;
        repeat (4) step(s);
        s = idle();  s.v = 1;  s.rb = 8;  s.wbwe = 1;  s.wbrd = 8;
        repeat (2) step(s);
        step(idle());

        for (int i = 0; i < 2000; i++) begin
            s.r     = ($urandom_range(0, 99) == 0);
            s.v     = ($urandom_range(0, 7) != 0);
            s.fl    = ($urandom_range(0, 7) == 0);
            s.lg    = ($urandom_range(0, 3) == 0);
            s.we    = $urandom_range(0, 1);
            s.exwe  = $urandom_range(0, 1);
            s.exld  = ($urandom_range(0, 3) == 0);
            s.memwe = $urandom_range(0, 1);
            s.wbwe  = $urandom_range(0, 1);
            s.ra    = $urandom_range(0, 7);
            s.rb    = $urandom_range(0, 7);
            s.rd    = $urandom_range(0, 7);
            s.exrd  = $urandom_range(0, 7);
            s.memrd = $urandom_range(0, 7);
            s.wbrd  = $urandom_range(0, 7);
            s.lat   = $urandom_range(0, 6);
            step(s);
        end

        for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (carried for consistency; no data ports).
REQ-002 SHALL have parameter ADDR_SIZE, default 5, register address width.
REQ-003 SHALL have parameter LAT_W, default 4, width of the long-op latency counter.
REQ-004 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: D_valid in 1 decode holds a valid instruction; D_ra, D_rb in ADDR_SIZE source registers; D_rd in ADDR_SIZE destination.
REQ-007 SHALL have ports: D_we in 1 decode writes rd; D_long in 1 decode is a multi-cycle op; D_lat in LAT_W long-op latency in cycles.
REQ-008 SHALL have ports: EX_rd, MEM_rd, WB_rd in ADDR_SIZE; EX_we, MEM_we, WB_we in 1; EX_ld in 1 EX holds a load.
REQ-009 SHALL have ports: flush in 1 kill decode instruction (taken branch).
REQ-010 SHALL have ports: stall_D out 1 hold F/D; ra_sel, rb_sel out 2 operand source (00 regfile, 01 EX, 10 MEM, 11 WB); long_busy out 1 long unit occupied.

Function
REQ-011 SHALL treat register address 0 as never matching any hazard or forward comparison.
REQ-012 SHALL compute ra_sel/rb_sel combinationally with priority EX > MEM > WB; EX is eligible only when EX_ld=0.
REQ-013 SHALL drive ra_sel=rb_sel=00 and stall_D=0 when D_valid=0 or flush=1.
REQ-014 SHALL assert stall_D on load-use: EX_ld && EX_we && EX_rd matches D_ra or D_rb.
REQ-015 SHALL hold internal state L_cnt (LAT_W bits) and L_rd (ADDR_SIZE); long_busy = (L_cnt != 0).
REQ-016 SHALL assert stall_D when long_busy and L_rd matches D_ra, D_rb (RAW) or D_rd with D_we=1 (WAW).
REQ-017 SHALL assert stall_D when D_long=1 and long_busy=1 (structural), including when L_cnt=1.
REQ-018 SHALL issue a long op when D_valid && D_long && !stall_D && !flush: next cycle L_cnt = D_lat (D_lat=0 treated as 1), L_rd = D_rd.
REQ-019 SHALL decrement L_cnt by 1 each cycle while non-zero and not issuing; release L_rd tracking when L_cnt reaches 0.
REQ-020 SHALL NOT cancel an in-flight long op on flush; flush only blocks new issue.
REQ-021 SHALL keep L_cnt/L_rd unchanged while stall_D=1 except for the normal decrement.

Reset
REQ-022 SHALL on rst=1 at a clock edge set L_cnt=0 and L_rd=0, so long_busy=0 next cycle; reset mid long-op SHALL abandon it.
REQ-023 SHALL after reset present stall_D=0, ra_sel=rb_sel=00 for any D_valid=0 input.
REQ-024 SHALL clear performance counters to 0 on reset when the feature in REQ-025 is compiled in.

Configuration
REQ-025 SHALL, with macro HAZARD_SCOREBOARD_PERF_EN defined, add outputs perf_stall_cnt out 32 and perf_fwd_cnt out 32: +1 per cycle with stall_D=1; +1 per cycle with any sel != 00 and stall_D=0; both saturate at 0xFFFFFFFF.
REQ-026 SHALL, without HAZARD_SCOREBOARD_PERF_EN, omit those ports and counters entirely with identical functional behaviour.

Verification
REQ-027 SHALL test: EX_we=1 EX_rd=3 MEM_we=1 MEM_rd=3, D_ra=3 -> ra_sel=01; then EX_we=0 -> ra_sel=10.
REQ-028 SHALL test: EX_ld=1 EX_we=1 EX_rd=5, D_rb=5 -> stall_D=1, rb_sel=00; D_rb=0 with EX_rd=0 -> stall_D=0, rb_sel=00.
REQ-029 SHALL test: issue D_long D_lat=3 D_rd=7 -> long_busy high 3 cycles; D_ra=7 stalls those cycles, released on the 4th.
REQ-030 SHALL test: second D_long while L_cnt=1 -> stall_D=1 that cycle; issues next cycle with new L_cnt=D_lat.
REQ-031 SHALL test: flush=1 with D_long valid -> no issue, stall_D=0; rst=1 with L_cnt=5 -> long_busy=0 next cycle.
REQ-032 SHALL test (PERF_EN): 4 stall cycles plus 2 forward cycles -> perf_stall_cnt=4, perf_fwd_cnt=2.
